// File: rtl/trap_int_sel.sv
// Interrupt pending/enable/priority selection plus WFI wait control for the privileged unit.
// Sits between raw interrupt sources, interrupt CSRs and the M-stage trap logic.
module trap_int_sel #(
  parameter int                 NUM_INT     = 32,
  parameter logic [NUM_INT-1:0] EDGE_MASK   = '0,
  parameter int                 WFI_TIMEOUT = 0,
  parameter bit                 S_SUPPORTED = 1'b1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_INT-1:0] IntSrcM,
  input  logic [NUM_INT-1:0] MIE_REGW,
  input  logic [NUM_INT-1:0] MIDELEG_REGW,
  input  logic [1:0]         PrivilegeModeW,
  input  logic               STATUS_MIE,
  input  logic               STATUS_SIE,
  input  logic               STATUS_TW,
  input  logic               InstrValidM,
  input  logic               CommittedM,
  input  logic               wfiM,
  output logic [NUM_INT-1:0] IntPendingOutM,
  output logic               IntPendingM,
  output logic               InterruptM,
  output logic [5:0]         IntCauseM,
  output logic               IntDelegateM,
  output logic               WfiStallM,
  output logic               WfiTimeoutM
);

  // Causes that may ever be pending: odd standard causes below 12 and all local causes.
  function automatic logic [NUM_INT-1:0] legal_causes();
    logic [NUM_INT-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_INT; i++) m[i] = (i >= 16) || (i < 12 && (i % 2) == 1);
    return m;
  endfunction

  localparam logic [NUM_INT-1:0] LEGAL = legal_causes();
  localparam int STD_ORDER [6] = '{11, 3, 7, 9, 1, 5};
  localparam int CNT_W = (WFI_TIMEOUT > 0) ? $clog2(WFI_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((WFI_TIMEOUT > 0) ? WFI_TIMEOUT - 1 : 0);
  localparam bit IMMEDIATE = (WFI_TIMEOUT == 0);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} wfi_state_t;

  logic [NUM_INT-1:0] src_q, pend_q, pending, deleg, valid, take;
  logic [5:0]         cause;
  logic               sel_deleg, is_m, m_en, s_en, tw_active, wfi_go;
  logic               stall, tout, cnt_load, cnt_inc;
  logic [CNT_W-1:0]   cnt;
  wfi_state_t         state, state_next;

  assign pending = LEGAL & ((EDGE_MASK & pend_q) | (~EDGE_MASK & IntSrcM));
  assign deleg   = S_SUPPORTED ? MIDELEG_REGW : '0;
  assign is_m    = (PrivilegeModeW == 2'b11);
  assign m_en    = ~is_m | STATUS_MIE;
  assign s_en    = (PrivilegeModeW == 2'b00) | ((PrivilegeModeW == 2'b01) & STATUS_SIE);
  assign valid   = CommittedM ? '0
                 : (({NUM_INT{m_en}} & pending & MIE_REGW & ~deleg) |
                    ({NUM_INT{s_en}} & pending & MIE_REGW & deleg));

  // Lowest-priority candidates are written first so higher ones overwrite them.
  always_comb begin
    cause     = '0;
    sel_deleg = 1'b0;
    for (int i = NUM_INT - 1; i >= 16; i--) begin
      if (valid[i]) begin
        cause     = 6'(i);
        sel_deleg = deleg[i];
      end
    end
    for (int k = 5; k >= 0; k--) begin
      if (valid[STD_ORDER[k]]) begin
        cause     = 6'(STD_ORDER[k]);
        sel_deleg = deleg[STD_ORDER[k]];
      end
    end
  end

  assign InterruptM     = (|valid) & InstrValidM & ~wfiM;
  assign IntCauseM      = cause;
  assign IntDelegateM   = InterruptM & sel_deleg & ~is_m;
  assign IntPendingOutM = pending;
  assign IntPendingM    = |(pending & MIE_REGW);

  always_comb begin
    take = '0;
    for (int i = 0; i < NUM_INT; i++) take[i] = InterruptM && (cause == 6'(i));
  end

  // A new rising edge beats the clear caused by taking the same cause.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      src_q  <= '0;
      pend_q <= '0;
    end else begin
      src_q  <= IntSrcM;
      pend_q <= EDGE_MASK & LEGAL & ((IntSrcM & ~src_q) | (pend_q & ~take));
    end
  end

  assign tw_active = STATUS_TW & ~is_m;
  assign wfi_go    = wfiM & InstrValidM;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      if (cnt_load)                  cnt <= '0;
      else if (cnt_inc && cnt != '1) cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    stall      = 1'b0;
    tout       = 1'b0;
    cnt_load   = 1'b0;
    cnt_inc    = 1'b0;
    case (state)
      IDLE: begin
        if (wfi_go && IntPendingM) begin
          state_next = DONE;
        end else if (wfi_go && tw_active && IMMEDIATE) begin
          tout = 1'b1;
        end else if (wfi_go) begin
          state_next = WAIT;
          stall      = 1'b1;
          cnt_load   = 1'b1;
        end
      end
      WAIT: begin
        stall = 1'b1;
        if (IntPendingM) begin
          state_next = DONE;
        end else if (tw_active && (IMMEDIATE || cnt == CNT_LAST)) begin
          tout       = 1'b1;
          state_next = IDLE;
        end else begin
          cnt_inc = tw_active;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Reset releases the pipeline immediately even while wfiM is still held.
  assign WfiStallM   = stall & reset_n;
  assign WfiTimeoutM = tout & reset_n;

endmodule

// File: tb/tb_trap_int_sel.sv
// Randomized and directed self-checking bench for trap_int_sel using two parameterisations
// (A: timeout 4 with S-mode, B: immediate timeout without S-mode).
module tb_trap_int_sel;
  localparam logic [31:0] EMASK = 32'h00F0_0002;

  typedef struct packed {
    logic [31:0] src, mie, mideleg;
    logic [1:0]  priv;
    logic        st_mie, st_sie, st_tw, iv, committed, wfi;
  } stim_t;

  typedef struct packed {
    logic [31:0] pend_out;
    logic        pend, intr;
    logic [5:0]  cause;
    logic        dlg;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [31:0] int_src, mie, mideleg;
  logic [1:0]  priv;
  logic        st_mie, st_sie, st_tw, iv, committed, wfi;
  logic [31:0] a_pend_out, b_pend_out;
  logic        a_pend, a_intr, a_dlg, a_stall, a_tout;
  logic        b_pend, b_intr, b_dlg, b_stall, b_tout;
  logic [5:0]  a_cause, b_cause;

  int    n_cmp = 0;
  int    n_bad = 0;
  stim_t st;

  always #5 clk = ~clk;

  trap_int_sel #(.NUM_INT(32), .EDGE_MASK(EMASK), .WFI_TIMEOUT(4), .S_SUPPORTED(1'b1)) dut_a (
    .clk(clk), .reset_n(reset_n), .IntSrcM(int_src), .MIE_REGW(mie), .MIDELEG_REGW(mideleg),
    .PrivilegeModeW(priv), .STATUS_MIE(st_mie), .STATUS_SIE(st_sie), .STATUS_TW(st_tw),
    .InstrValidM(iv), .CommittedM(committed), .wfiM(wfi),
    .IntPendingOutM(a_pend_out), .IntPendingM(a_pend), .InterruptM(a_intr), .IntCauseM(a_cause),
    .IntDelegateM(a_dlg), .WfiStallM(a_stall), .WfiTimeoutM(a_tout));

  trap_int_sel #(.NUM_INT(32), .EDGE_MASK(EMASK), .WFI_TIMEOUT(0), .S_SUPPORTED(1'b0)) dut_b (
    .clk(clk), .reset_n(reset_n), .IntSrcM(int_src), .MIE_REGW(mie), .MIDELEG_REGW(mideleg),
    .PrivilegeModeW(priv), .STATUS_MIE(st_mie), .STATUS_SIE(st_sie), .STATUS_TW(st_tw),
    .InstrValidM(iv), .CommittedM(committed), .wfiM(wfi),
    .IntPendingOutM(b_pend_out), .IntPendingM(b_pend), .InterruptM(b_intr), .IntCauseM(b_cause),
    .IntDelegateM(b_dlg), .WfiStallM(b_stall), .WfiTimeoutM(b_tout));

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input stim_t s);
    int_src   = s.src;
    mie       = s.mie;
    mideleg   = s.mideleg;
    priv      = s.priv;
    st_mie    = s.st_mie;
    st_sie    = s.st_sie;
    st_tw     = s.st_tw;
    iv        = s.iv;
    committed = s.committed;
    wfi       = s.wfi;
  endtask

  task automatic step();
    @(negedge clk);
    applyStimulus(st);
    #1;
  endtask

  task automatic doReset(input bit check);
    @(negedge clk);
    st = '0;
    applyStimulus(st);
    reset_n = 1'b0;
    #1;
    if (check) begin
      checkOutput("rst_a_pend_out", a_pend_out, 0);
      checkOutput("rst_a_intr", a_intr, 0);
      checkOutput("rst_a_cause", a_cause, 0);
      checkOutput("rst_a_stall", a_stall, 0);
      checkOutput("rst_a_tout", a_tout, 0);
      checkOutput("rst_b_tout", b_tout, 0);
      checkOutput("rst_b_dlg", b_dlg, 0);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Reference: the effective pending vector and the first enabled cause in architectural priority order.
  function automatic exp_t model(input stim_t s, input logic [31:0] pe, input bit s_sup);
    exp_t e;
    logic [31:0] p, dl;
    bit m_en, s_en, legal;
    int order[$];
    int sel;
    e   = '0;
    p   = '0;
    sel = -1;
    for (int i = 0; i < 32; i++) begin
      legal = (i >= 16) || (i < 12 && (i % 2) == 1);
      if (legal) p[i] = EMASK[i] ? pe[i] : s.src[i];
    end
    dl   = s_sup ? s.mideleg : 32'h0;
    m_en = (s.priv != 2'd3) || s.st_mie;
    s_en = (s.priv == 2'd0) || (s.priv == 2'd1 && s.st_sie);
    e.pend_out = p;
    e.pend     = |(p & s.mie);
    order = '{11, 3, 7, 9, 1, 5};
    for (int i = 16; i < 32; i++) order.push_back(i);
    foreach (order[k]) begin
      if (sel < 0 && !s.committed && p[order[k]] && s.mie[order[k]] && (dl[order[k]] ? s_en : m_en))
        sel = order[k];
    end
    if (sel >= 0) e.cause = 6'(sel);
    e.intr = (sel >= 0) && s.iv && !s.wfi;
    e.dlg  = e.intr && dl[sel] && (s.priv != 2'd3);
    return e;
  endfunction

  function automatic logic [31:0] nextPend(input stim_t s, input logic [31:0] pe, input logic [31:0] prev,
                                           input exp_t e);
    logic [31:0] n;
    n = pe;
    for (int i = 0; i < 32; i++) begin
      if (EMASK[i]) begin
        if (s.src[i] && !prev[i])                n[i] = 1'b1;
        else if (e.intr && int'(e.cause) == i)   n[i] = 1'b0;
      end
    end
    return n;
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] mpa, mpb, mprev;
    exp_t ea, eb;
    int pulses;

    st = '0;
    applyStimulus(st);
    doReset(1'b1);

    mpa = '0;
    mpb = '0;
    mprev = '0;
    for (int c = 0; c < 400; c++) begin
      st.src       = $urandom & $urandom;
      st.mie       = $urandom | $urandom;
      st.mideleg   = $urandom;
      case ($urandom_range(0, 2))
        0:       st.priv = 2'd0;
        1:       st.priv = 2'd1;
        default: st.priv = 2'd3;
      endcase
      st.st_mie    = 1'($urandom_range(0, 1));
      st.st_sie    = 1'($urandom_range(0, 1));
      st.st_tw     = 1'($urandom_range(0, 1));
      st.iv        = ($urandom_range(0, 7) != 0);
      st.committed = ($urandom_range(0, 7) == 0);
      st.wfi       = 1'b0;
      step();
      ea = model(st, mpa, 1'b1);
      eb = model(st, mpb, 1'b0);
      checkOutput("rnd_a_pend_out", a_pend_out, ea.pend_out);
      checkOutput("rnd_a_pend", a_pend, ea.pend);
      checkOutput("rnd_a_intr", a_intr, ea.intr);
      checkOutput("rnd_a_cause", a_cause, ea.cause);
      checkOutput("rnd_a_dlg", a_dlg, ea.dlg);
      checkOutput("rnd_a_stall", a_stall, 0);
      checkOutput("rnd_b_pend_out", b_pend_out, eb.pend_out);
      checkOutput("rnd_b_intr", b_intr, eb.intr);
      checkOutput("rnd_b_cause", b_cause, eb.cause);
      checkOutput("rnd_b_dlg", b_dlg, eb.dlg);
      checkOutput("rnd_b_tout", b_tout, 0);
      mpa   = nextPend(st, mpa, mprev, ea);
      mpb   = nextPend(st, mpb, mprev, eb);
      mprev = st.src;
    end

    // Level machine external interrupt
    doReset(1'b0);
    st.src[11] = 1'b1; st.mie[11] = 1'b1; st.priv = 2'd3; st.st_mie = 1'b1; st.iv = 1'b1;
    step();
    checkOutput("mei_intr", a_intr, 1);
    checkOutput("mei_cause", a_cause, 11);
    checkOutput("mei_dlg", a_dlg, 0);

    // Priority between standard and local causes
    doReset(1'b0);
    st.priv = 2'd3; st.st_mie = 1'b1; st.iv = 1'b1;
    st.mie = 32'h0011_0080;
    st.src = 32'h0011_0080;
    step();
    checkOutput("prio_7", a_cause, 7);
    st.src[7] = 1'b0;
    step();
    checkOutput("prio_16", a_cause, 16);

    // Edge-triggered source 20: latch, clear on take, set beats clear
    doReset(1'b0);
    st.priv = 2'd3; st.st_mie = 1'b1; st.mie[20] = 1'b1; st.iv = 1'b0;
    st.src[20] = 1'b1; step();
    checkOutput("edge_not_yet", a_pend_out[20], 0);
    st.src[20] = 1'b0; step();
    checkOutput("edge_latched", a_pend_out[20], 1);
    step();
    checkOutput("edge_held", a_pend_out[20], 1);
    st.iv = 1'b1; step();
    checkOutput("edge_take_intr", a_intr, 1);
    checkOutput("edge_take_cause", a_cause, 20);
    st.iv = 1'b0; step();
    checkOutput("edge_cleared", a_pend_out[20], 0);
    st.src[20] = 1'b1; step();
    st.src[20] = 1'b0; step();
    checkOutput("edge_relatched", a_pend_out[20], 1);
    st.iv = 1'b1; st.src[20] = 1'b1; step();
    checkOutput("edge_take2_intr", a_intr, 1);
    st.iv = 1'b0; st.src[20] = 1'b0; step();
    checkOutput("edge_set_wins", a_pend_out[20], 1);

    // Delegation of supervisor external interrupt
    doReset(1'b0);
    st.src[9] = 1'b1; st.mie[9] = 1'b1; st.mideleg[9] = 1'b1;
    st.priv = 2'd1; st.st_sie = 1'b1; st.st_mie = 1'b0; st.iv = 1'b1;
    step();
    checkOutput("deleg_a_intr", a_intr, 1);
    checkOutput("deleg_a_cause", a_cause, 9);
    checkOutput("deleg_a_dlg", a_dlg, 1);
    checkOutput("deleg_b_intr", b_intr, 1);
    checkOutput("deleg_b_dlg", b_dlg, 0);
    st.priv = 2'd3;
    step();
    checkOutput("deleg_m_off_a", a_intr, 0);
    checkOutput("deleg_m_off_b", b_intr, 0);
    st.st_mie = 1'b1;
    step();
    checkOutput("deleg_m_on_a", a_intr, 0);
    checkOutput("deleg_m_on_b", b_intr, 1);
    checkOutput("deleg_m_on_b_dlg", b_dlg, 0);

    // WFI wait without TW, woken by MTI-class cause 7
    doReset(1'b0);
    st.priv = 2'd0; st.mie[7] = 1'b1; st.wfi = 1'b1; st.iv = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      checkOutput("wfi_stall_a", a_stall, 1);
      checkOutput("wfi_stall_b", b_stall, 1);
    end
    st.src[7] = 1'b1; step();
    checkOutput("wfi_wake_stall", a_stall, 1);
    checkOutput("wfi_wake_intr", a_intr, 0);
    step();
    checkOutput("wfi_done_stall", a_stall, 0);
    checkOutput("wfi_done_intr", a_intr, 0);
    st.wfi = 1'b0; step();
    checkOutput("wfi_after_intr", a_intr, 1);
    checkOutput("wfi_after_cause", a_cause, 7);

    // TW timeout: 4-cycle counter on A, immediate on B
    doReset(1'b0);
    st.priv = 2'd1; st.st_tw = 1'b1; st.wfi = 1'b1; st.iv = 1'b1;
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (a_tout === 1'b1) pulses++;
      checkOutput($sformatf("tout_a_c%0d", c), a_tout, (c == 4) ? 1 : 0);
      if (c == 0) begin
        checkOutput("tout_a_entry_stall", a_stall, 1);
        checkOutput("tout_b_immediate", b_tout, 1);
        checkOutput("tout_b_no_stall", b_stall, 0);
      end
    end
    checkOutput("tout_a_pulses", pulses, 1);

    // Reset asserted mid-WAIT drops the stall at once
    doReset(1'b0);
    st.priv = 2'd0; st.wfi = 1'b1; st.iv = 1'b1;
    repeat (3) step();
    checkOutput("rstwait_pre", a_stall, 1);
    #1;
    reset_n = 1'b0;
    #1;
    checkOutput("rstwait_a", a_stall, 0);
    checkOutput("rstwait_b", b_stall, 0);
    @(negedge clk);
    st = '0;
    applyStimulus(st);
    reset_n = 1'b1;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
